register_file_mp: RTL and testbench

Parametrised multi-port register file for the pipelined CPU. It is the successor to the single-write / dual-read register file.
- Configurable data width, register count, read-port count and write-port count.
- Register 0 is hardwired to zero.
- Adds a per-register busy scoreboard, set at issue and cleared at writeback, so decode can detect RAW hazards.
- Sits between decode (reads, issue) and writeback (writes).

---
 rtl/register_file_mp.sv | 119 +++++++++++
 tb/tb_register_file_mp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp
// ---------------------------------------------------------------------------
// Purpose: parametrised multi-port register file with a per-register busy
// scoreboard for RAW hazard detection. Register 0 is hardwired to zero.
// Reads are combinational. Writes, issue marks and flushes take effect on
// the rising CLK edge. The active-low reset nRST is asynchronous.
//
// Ports:
//   CLK        system clock, rising-edge active
//   nRST       asynchronous active-low reset (clears registers and scoreboard)
//   wen        per-port write enable                 [NWR]
//   wsel       per-port write select, port i at [i*AW +: AW]
//   wdat       per-port write data,   port i at [i*DATA_W +: DATA_W]
//   rsel       per-port read select,  port j at [j*AW +: AW]
//   rdat       per-port read data,    port j at [j*DATA_W +: DATA_W]
//   rbusy      busy bit of the register selected on each read port
//   issue_en   mark issue_sel as pending at the next edge
//   issue_sel  destination register being issued
//   flush      clear the whole scoreboard (overrides issue_en)
//   busy       full scoreboard vector, bit r = register r pending
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When defined, same-cycle write data is forwarded to rdat, and rbusy is
//   forced low when a same-cycle write retires the register and no issue
//   targets it in that cycle. When undefined, reads see only registered state.
// ---------------------------------------------------------------------------
module register_file_mp #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NWR-1:0]         wen,
    input  logic [NWR*AW-1:0]      wsel,
    input  logic [NWR*DATA_W-1:0]  wdat,
    input  logic [NRD*AW-1:0]      rsel,
    output logic [NRD*DATA_W-1:0]  rdat,
    output logic [NRD-1:0]         rbusy,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_sel,
    input  logic                   flush,
    output logic [NREGS-1:0]       busy
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // Register array next state. Ports are visited in ascending order so the
    // highest-index port writing a register wins a conflict.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NWR; i++) begin
            if (wen[i] && (wsel[i*AW +: AW] != '0)) begin
                regs_d[wsel[i*AW +: AW]] = wdat[i*DATA_W +: DATA_W];
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard next state. Priority, lowest to highest: write-back clear,
    // issue set (a new producer supersedes the retiring one), flush.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 0; i < NWR; i++) begin
            if (wen[i] && (wsel[i*AW +: AW] != '0)) begin
                busy_d[wsel[i*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en && (issue_sel != '0)) begin
            busy_d[issue_sel] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports.
    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            if (rsel[j*AW +: AW] != '0) begin
                rdat[j*DATA_W +: DATA_W] = regs_q[rsel[j*AW +: AW]];
                rbusy[j]                 = busy_q[rsel[j*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (wen[i] && (wsel[i*AW +: AW] == rsel[j*AW +: AW])) begin
                        rdat[j*DATA_W +: DATA_W] = wdat[i*DATA_W +: DATA_W];
                        rbusy[j]                 = 1'b0;
                    end
                end
                // A same-cycle issue to this register keeps it pending.
                if (issue_en && (issue_sel == rsel[j*AW +: AW])) begin
                    rbusy[j] = busy_q[rsel[j*AW +: AW]];
                end
`endif
            end
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic                  CLK;
    logic                  nRST;
    logic [NWR-1:0]        wen;
    logic [NWR*AW-1:0]     wsel;
    logic [NWR*DW-1:0]     wdat;
    logic [NRD*AW-1:0]     rsel;
    logic [NRD*DW-1:0]     rdat;
    logic [NRD-1:0]        rbusy;
    logic                  issue_en;
    logic [AW-1:0]         issue_sel;
    logic                  flush;
    logic [NR-1:0]         busy;

    register_file_mp #(
        .DATA_W (DW),
        .NREGS  (NR),
        .NRD    (NRD),
        .NWR    (NWR)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .wen       (wen),
        .wsel      (wsel),
        .wdat      (wdat),
        .rsel      (rsel),
        .rdat      (rdat),
        .rbusy     (rbusy),
        .issue_en  (issue_en),
        .issue_sel (issue_sel),
        .flush     (flush),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: architectural state as plain arrays.
    logic [DW-1:0] mregs [NR];
    logic [NR-1:0] mbusy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] wsel_of(input int unsigned i);
        return wsel[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wdat_of(input int unsigned i);
        return wdat[i*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] rsel_of(input int unsigned j);
        return rsel[j*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] exp_rdat(input int unsigned j);
        logic [AW-1:0] s;
        logic [DW-1:0] v;
        s = rsel_of(j);
        if (s == 0) return '0;
        v = mregs[s];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned i = 0; i < NWR; i++)
            if (wen[i] && wsel_of(i) == s) v = wdat_of(i);
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(input int unsigned j);
        logic [AW-1:0] s;
        logic b;
        s = rsel_of(j);
        if (s == 0) return 1'b0;
        b = mbusy[s];
`ifdef REGFILE_BYPASS_EN
        begin
            logic retiring;
            retiring = 1'b0;
            for (int unsigned i = 0; i < NWR; i++)
                if (wen[i] && wsel_of(i) == s) retiring = 1'b1;
            if (retiring && !(issue_en && issue_sel == s)) b = 1'b0;
        end
`endif
        return b;
    endfunction

    // Apply one clock edge worth of architectural effects to the model.
    task automatic model_edge();
        for (int unsigned i = 0; i < NWR; i++) begin
            if (wen[i] && wsel_of(i) != 0) begin
                mregs[wsel_of(i)] = wdat_of(i);
                mbusy[wsel_of(i)] = 1'b0;
            end
        end
        if (issue_en && issue_sel != 0) mbusy[issue_sel] = 1'b1;
        if (flush) mbusy = '0;
    endtask

    task automatic model_reset();
        for (int unsigned r = 0; r < NR; r++) mregs[r] = '0;
        mbusy = '0;
    endtask

    task automatic idle();
        wen = '0; wsel = '0; wdat = '0;
        issue_en = 1'b0; issue_sel = '0; flush = 1'b0;
    endtask

    // Compare all outputs mid-cycle, then advance one edge.
    task automatic tick();
        @(negedge CLK);
        for (int unsigned j = 0; j < NRD; j++) begin
            check($sformatf("rdat%0d", j), rdat[j*DW +: DW], exp_rdat(j));
            check($sformatf("rbusy%0d", j), {31'b0, rbusy[j]}, {31'b0, exp_rbusy(j)});
        end
        check("busy", busy, mbusy);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic wr(input int unsigned port, input logic [AW-1:0] s, input logic [DW-1:0] d);
        wen[port] = 1'b1;
        wsel[port*AW +: AW] = s;
        wdat[port*DW +: DW] = d;
    endtask

    task automatic rd_all(input logic [AW-1:0] s);
        for (int unsigned j = 0; j < NRD; j++) rsel[j*AW +: AW] = s;
    endtask

    initial begin
        idle();
        rsel = '0;
        model_reset();
        nRST = 1'b0;
        #12;
        rd_all(5'd5);
        #1;
        check("reset_rdat", rdat[DW-1:0], 32'h0);
        check("reset_busy", busy, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Zero register: writes to r0 are discarded.
        idle(); wr(0, 5'd0, 32'hFFFF_FFFF); rd_all(5'd0);
        tick();
        idle();
        #1;
        check("zero_rdat0", rdat[0 +: DW], 32'h0);
        check("zero_rdat1", rdat[DW +: DW], 32'h0);
        check("zero_rbusy", {30'b0, rbusy}, 32'h0);
        tick();

        // Write r7, then read it on every port.
        idle(); wr(0, 5'd7, 32'h1234_5678); rd_all(5'd7);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_r7", rdat[0 +: DW], 32'h1234_5678);
`else
        check("same_cycle_r7", rdat[0 +: DW], 32'h0);
`endif
        tick();
        idle();
        #1;
        check("r7_port0", rdat[0 +: DW], 32'h1234_5678);
        check("r7_port1", rdat[DW +: DW], 32'h1234_5678);
        tick();

        // Write conflict: highest port wins.
        idle(); wr(0, 5'd3, 32'h0000_AAAA); wr(1, 5'd3, 32'h0000_5555);
        tick();
        idle(); rd_all(5'd3);
        #1;
        check("conflict_r3", rdat[0 +: DW], 32'h0000_5555);
        tick();

        // Scoreboard set then clear.
        idle(); issue_en = 1'b1; issue_sel = 5'd9;
        tick();
        idle(); rd_all(5'd9);
        #1;
        check("issue_r9", {31'b0, busy[9]}, 32'h1);
        check("rbusy_r9", {31'b0, rbusy[0]}, 32'h1);
        wr(0, 5'd9, 32'h42);
        tick();
        idle();
        #1;
        check("wb_r9", {31'b0, busy[9]}, 32'h0);

        // Collision: issue and write-back of r9 in the same cycle.
        issue_en = 1'b1; issue_sel = 5'd9; wr(1, 5'd9, 32'h42);
        tick();
        idle();
        #1;
        check("collide_busy9", {31'b0, busy[9]}, 32'h1);
        check("collide_r9", rdat[0 +: DW], 32'h42);
        tick();

        // Flush: overrides a same-cycle issue; register data untouched.
        idle(); wr(0, 5'd4, 32'h4444_0004); wr(1, 5'd6, 32'h6666_0006);
        tick();
        idle(); issue_en = 1'b1; issue_sel = 5'd4;
        tick();
        idle(); issue_en = 1'b1; issue_sel = 5'd6;
        tick();
        idle();
        #1;
        check("pre_flush_b4", {31'b0, busy[4]}, 32'h1);
        check("pre_flush_b6", {31'b0, busy[6]}, 32'h1);
        flush = 1'b1; issue_en = 1'b1; issue_sel = 5'd8;
        tick();
        idle();
        rsel = {5'd6, 5'd4};
        #1;
        check("flush_busy", busy, 32'h0);
        check("flush_r4", rdat[0 +: DW], 32'h4444_0004);
        check("flush_r6", rdat[DW +: DW], 32'h6666_0006);
        tick();

        // Asynchronous reset mid-run.
        idle(); wr(0, 5'd5, 32'hDEAD_BEEF); issue_en = 1'b1; issue_sel = 5'd2;
        tick();
        idle(); rd_all(5'd5);
        #1;
        check("r5_written", rdat[0 +: DW], 32'hDEAD_BEEF);
        #1;
        nRST = 1'b0;
        #1;
        model_reset();
        check("async_rst_r5", rdat[0 +: DW], 32'h0);
        check("async_rst_busy", busy, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int unsigned i = 0; i < NWR; i++) begin
                wen[i] = ($urandom_range(0, 2) != 0);
                wsel[i*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                             : AW'($urandom_range(0, NR-1));
                wdat[i*DW +: DW] = $urandom;
            end
            for (int unsigned j = 0; j < NRD; j++)
                rsel[j*AW +: AW] = AW'($urandom_range(0, 7));
            issue_en  = ($urandom_range(0, 1) != 0);
            issue_sel = AW'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
